// File: rtl/calc2_pkg.sv
// Shared types and encodings for the calc2 request port.
// Data, tag and response fields keep calc2 bit order: bit 0 is the MSB.
package calc2_pkg;

  localparam int NUM_TAGS = 4;

  typedef logic [0:3]  cmd_t;
  typedef logic [0:31] data_t;
  typedef logic [0:1]  tag_t;
  typedef logic [0:1]  resp_t;

  localparam cmd_t CMD_NOP = 4'h0;
  localparam cmd_t CMD_ADD = 4'h1;
  localparam cmd_t CMD_SUB = 4'h2;
  localparam cmd_t CMD_SHL = 4'h5;
  localparam cmd_t CMD_SHR = 4'h6;

  localparam resp_t RESP_NONE    = 2'b00;
  localparam resp_t RESP_OK      = 2'b01;
  localparam resp_t RESP_ERR     = 2'b10;
  localparam resp_t RESP_TIMEOUT = 2'b11;

  function automatic tag_t lowest_idx(input logic [NUM_TAGS-1:0] m);
    lowest_idx = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = tag_t'(i);
    end
  endfunction

endpackage

// File: rtl/calc2_tag_tracker.sv
// Outstanding-tag map with per-tag timers.
// Provides the lowest free tag and the lowest expired tag.
module calc2_tag_tracker
  import calc2_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                c_clk,
  input  logic                reset,
  input  logic                mark_en,
  input  logic [0:1]          mark_tag,
  input  logic                free_en,
  input  logic [0:1]          free_tag_in,
  output logic [NUM_TAGS-1:0] out_map,
  output logic                free_ok,
  output logic [0:1]          free_tag,
  output logic                exp_ok,
  output logic [0:1]          exp_tag
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  logic [NUM_TAGS-1:0] out_q, out_d;
  logic [NUM_TAGS-1:0] exp_map;
  logic [7:0]          timer_q [NUM_TAGS];
  logic [7:0]          timer_d [NUM_TAGS];

  // Timer loads 1 with the operand-2 beat, so it counts that beat's cycle.
  always_comb begin
    out_d = out_q;
    for (int i = 0; i < NUM_TAGS; i++) begin
      timer_d[i] = timer_q[i];
      exp_map[i] = out_q[i] && (timer_q[i] == TMO);
      if (out_q[i] && !exp_map[i]) timer_d[i] = timer_q[i] + 8'd1;
    end
    if (free_en) begin
      out_d[free_tag_in]   = 1'b0;
      timer_d[free_tag_in] = '0;
    end
    if (mark_en) begin
      out_d[mark_tag]   = 1'b1;
      timer_d[mark_tag] = 8'd1;
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
      for (int i = 0; i < NUM_TAGS; i++) timer_q[i] <= '0;
    end else begin
      out_q   <= out_d;
      timer_q <= timer_d;
    end
  end

  assign out_map  = out_q;
  assign free_ok  = |(~out_q);
  assign free_tag = lowest_idx(~out_q);
  assign exp_ok   = |exp_map;
  assign exp_tag  = lowest_idx(exp_map);

endmodule

// File: rtl/calc2_port_requester.sv
// calc2 port initiator: two-beat request serialiser, tag-matched
// completions and local timeout of lost responses.
module calc2_port_requester
  import calc2_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [0:3]  op_cmd,
  input  logic [0:31] op_data1,
  input  logic [0:31] op_data2,
  output logic [0:3]  req_cmd_out,
  output logic [0:31] req_data_out,
  output logic [0:1]  req_tag_out,
  input  logic [0:1]  rsp_resp_in,
  input  logic [0:31] rsp_data_in,
  input  logic [0:1]  rsp_tag_in,
  output logic        cpl_valid,
  output logic [0:1]  cpl_tag,
  output logic [0:1]  cpl_resp,
  output logic [0:31] cpl_data,
  output logic        spurious_rsp,
  output logic        busy
);

  typedef enum logic {S_IDLE, S_OP2} state_e;

  state_e state_q, state_d;
  cmd_t   req_cmd_q, req_cmd_d;
  data_t  req_data_q, req_data_d;
  tag_t   req_tag_q, req_tag_d;
  tag_t   cur_tag_q, cur_tag_d;
  data_t  op2_q, op2_d;
  logic   cpl_valid_q, cpl_valid_d;
  tag_t   cpl_tag_q, cpl_tag_d;
  resp_t  cpl_resp_q, cpl_resp_d;
  data_t  cpl_data_q, cpl_data_d;
  logic   spur_q, spur_d;

  logic [NUM_TAGS-1:0] out_map;
  logic free_ok, exp_ok, mark_en, free_en;
  tag_t free_tag, exp_tag, free_idx;
  logic rsp_any, rsp_hit, accept;

  calc2_tag_tracker #(.TIMEOUT(TIMEOUT)) u_trk (
    .c_clk       (c_clk),
    .reset       (reset),
    .mark_en     (mark_en),
    .mark_tag    (cur_tag_q),
    .free_en     (free_en),
    .free_tag_in (free_idx),
    .out_map     (out_map),
    .free_ok     (free_ok),
    .free_tag    (free_tag),
    .exp_ok      (exp_ok),
    .exp_tag     (exp_tag)
  );

  assign rsp_any  = rsp_resp_in != RESP_NONE;
  assign rsp_hit  = rsp_any && out_map[rsp_tag_in];
  assign op_ready = (state_q == S_IDLE) && free_ok && !reset;
  assign accept   = op_valid && op_ready;

  always_comb begin
    state_d    = state_q;
    req_cmd_d  = CMD_NOP;
    req_data_d = '0;
    req_tag_d  = '0;
    cur_tag_d  = cur_tag_q;
    op2_d      = op2_q;
    mark_en    = 1'b0;
    unique case (state_q)
      S_IDLE: if (accept) begin
        req_cmd_d  = op_cmd;
        req_data_d = op_data1;
        req_tag_d  = free_tag;
        cur_tag_d  = free_tag;
        op2_d      = op_data2;
        state_d    = S_OP2;
      end
      S_OP2: begin
        req_data_d = op2_q;
        mark_en    = 1'b1;
        state_d    = S_IDLE;
      end
    endcase
  end

  // A response (even for a tag expiring now) beats any timeout.
  always_comb begin
    cpl_valid_d = 1'b0;
    cpl_tag_d   = '0;
    cpl_resp_d  = RESP_NONE;
    cpl_data_d  = '0;
    free_en     = 1'b0;
    free_idx    = '0;
    spur_d      = rsp_any && !rsp_hit;
    if (rsp_hit) begin
      cpl_valid_d = 1'b1;
      cpl_tag_d   = rsp_tag_in;
      cpl_resp_d  = rsp_resp_in;
      cpl_data_d  = rsp_data_in;
      free_en     = 1'b1;
      free_idx    = rsp_tag_in;
    end else if (exp_ok) begin
      cpl_valid_d = 1'b1;
      cpl_tag_d   = exp_tag;
      cpl_resp_d  = RESP_TIMEOUT;
      free_en     = 1'b1;
      free_idx    = exp_tag;
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_cmd_q   <= '0;
      req_data_q  <= '0;
      req_tag_q   <= '0;
      cur_tag_q   <= '0;
      op2_q       <= '0;
      cpl_valid_q <= 1'b0;
      cpl_tag_q   <= '0;
      cpl_resp_q  <= '0;
      cpl_data_q  <= '0;
      spur_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_cmd_q   <= req_cmd_d;
      req_data_q  <= req_data_d;
      req_tag_q   <= req_tag_d;
      cur_tag_q   <= cur_tag_d;
      op2_q       <= op2_d;
      cpl_valid_q <= cpl_valid_d;
      cpl_tag_q   <= cpl_tag_d;
      cpl_resp_q  <= cpl_resp_d;
      cpl_data_q  <= cpl_data_d;
      spur_q      <= spur_d;
    end
  end

  assign req_cmd_out  = req_cmd_q;
  assign req_data_out = req_data_q;
  assign req_tag_out  = req_tag_q;
  assign cpl_valid    = cpl_valid_q;
  assign cpl_tag      = cpl_tag_q;
  assign cpl_resp     = cpl_resp_q;
  assign cpl_data     = cpl_data_q;
  assign spurious_rsp = spur_q;
  assign busy         = (state_q != S_IDLE) || (|out_map);

endmodule

// File: tb/tb_calc2_port_requester.sv
// Bench for calc2_port_requester: directed ops, scoreboard of
// expected completions checked by an independent monitor.
module tb_calc2_port_requester;
  import calc2_pkg::*;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [0:3]  op_cmd = '0;
  logic [0:31] op_data1 = '0;
  logic [0:31] op_data2 = '0;
  logic [0:3]  req_cmd_out;
  logic [0:31] req_data_out;
  logic [0:1]  req_tag_out;
  logic [0:1]  rsp_resp_in = '0;
  logic [0:31] rsp_data_in = '0;
  logic [0:1]  rsp_tag_in = '0;
  logic        cpl_valid;
  logic [0:1]  cpl_tag;
  logic [0:1]  cpl_resp;
  logic [0:31] cpl_data;
  logic        spurious_rsp;
  logic        busy;

  typedef struct {
    tag_t  tag;
    resp_t resp;
    data_t data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  calc2_port_requester #(.TIMEOUT(8)) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_cmd       (op_cmd),
    .op_data1     (op_data1),
    .op_data2     (op_data2),
    .req_cmd_out  (req_cmd_out),
    .req_data_out (req_data_out),
    .req_tag_out  (req_tag_out),
    .rsp_resp_in  (rsp_resp_in),
    .rsp_data_in  (rsp_data_in),
    .rsp_tag_in   (rsp_tag_in),
    .cpl_valid    (cpl_valid),
    .cpl_tag      (cpl_tag),
    .cpl_resp     (cpl_resp),
    .cpl_data     (cpl_data),
    .spurious_rsp (spurious_rsp),
    .busy         (busy)
  );

  always #5 c_clk = ~c_clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic push(input tag_t t, input resp_t r, input data_t d);
    exp_t e;
    e.tag  = t;
    e.resp = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Returns one step after the operand-2 beat becomes visible.
  task automatic issue(input cmd_t c, input data_t a, input data_t b,
                       input tag_t t);
    int n;
    n = 0;
    op_valid = 1'b1;
    op_cmd   = c;
    op_data1 = a;
    op_data2 = b;
    while (!op_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("op_ready_wait", 64'(op_ready), 64'd1);
    tick();
    op_valid = 1'b0;
    chk("beat1_cmd", 64'(req_cmd_out), 64'(c));
    chk("beat1_data", 64'(req_data_out), 64'(a));
    chk("beat1_tag", 64'(req_tag_out), 64'(t));
    tick();
    chk("beat2_cmd", 64'(req_cmd_out), 64'd0);
    chk("beat2_data", 64'(req_data_out), 64'(b));
    chk("beat2_tag", 64'(req_tag_out), 64'd0);
  endtask

  task automatic rsp(input resp_t r, input data_t d, input tag_t t);
    rsp_resp_in = r;
    rsp_data_in = d;
    rsp_tag_in  = t;
    tick();
    rsp_resp_in = RESP_NONE;
    rsp_data_in = '0;
    rsp_tag_in  = '0;
  endtask

  always @(negedge c_clk) begin
    if (!reset && cpl_valid) begin
      if (exp_q.size() == 0) begin
        chk("cpl_unexpected", 64'(cpl_tag), 64'hFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("cpl_tag", 64'(cpl_tag), 64'(e.tag));
        chk("cpl_resp", 64'(cpl_resp), 64'(e.resp));
        chk("cpl_data", 64'(cpl_data), 64'(e.data));
      end
    end
  end

  initial begin
    int seen;
    tick();
    tick();
    chk("rst_op_ready", 64'(op_ready), 64'd0);
    chk("rst_cmd", 64'(req_cmd_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cpl", 64'(cpl_valid), 64'd0);
    chk("rst_spur", 64'(spurious_rsp), 64'd0);
    reset = 1'b0;
    #1;
    chk("idle_ready", 64'(op_ready), 64'd1);

    // single add
    issue(CMD_ADD, 32'h5, 32'h3, 2'd0);
    chk("busy_out", 64'(busy), 64'd1);
    push(2'd0, RESP_OK, 32'h8);
    rsp(RESP_OK, 32'h8, 2'd0);
    chk("cpl_now", 64'(cpl_valid), 64'd1);
    tick();
    chk("idle_busy", 64'(busy), 64'd0);

    // fill all tags, then out-of-order responses
    issue(CMD_ADD, 32'h10, 32'h1, 2'd0);
    issue(CMD_SUB, 32'h20, 32'h2, 2'd1);
    issue(CMD_SHL, 32'h30, 32'h3, 2'd2);
    issue(CMD_SHR, 32'h40, 32'h4, 2'd3);
    chk("full_ready", 64'(op_ready), 64'd0);
    push(2'd2, RESP_OK, 32'h180);
    push(2'd0, RESP_OK, 32'h11);
    push(2'd3, RESP_ERR, 32'h0);
    push(2'd1, RESP_OK, 32'h1E);
    rsp(RESP_OK, 32'h180, 2'd2);
    chk("refill_ready", 64'(op_ready), 64'd1);
    rsp(RESP_OK, 32'h11, 2'd0);
    rsp(RESP_ERR, 32'h0, 2'd3);
    rsp(RESP_OK, 32'h1E, 2'd1);
    tick();
    chk("ooo_busy", 64'(busy), 64'd0);

    // lost response: timeout, then a late reply is spurious
    issue(CMD_SHL, 32'h1, 32'h4, 2'd0);
    push(2'd0, RESP_TIMEOUT, 32'h0);
    seen = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (cpl_valid && seen == 0) seen = k;
    end
    chk("tmo_latency", 64'(seen), 64'd8);
    rsp(RESP_OK, 32'h10, 2'd0);
    chk("late_spur", 64'(spurious_rsp), 64'd1);
    chk("late_no_cpl", 64'(cpl_valid), 64'd0);
    tick();
    chk("spur_pulse", 64'(spurious_rsp), 64'd0);
    rsp(RESP_OK, 32'h99, 2'd3);
    chk("idle_spur", 64'(spurious_rsp), 64'd1);

    // response and expiry in the same cycle
    issue(CMD_ADD, 32'h7, 32'h7, 2'd0);
    issue(CMD_SUB, 32'h9, 32'h2, 2'd1);
    for (int k = 0; k < 5; k++) tick();
    push(2'd1, RESP_OK, 32'h77);
    push(2'd0, RESP_TIMEOUT, 32'h0);
    rsp(RESP_OK, 32'h77, 2'd1);
    chk("race_first", 64'(cpl_tag), 64'd1);
    tick();
    chk("race_second", 64'(cpl_resp), 64'(RESP_TIMEOUT));
    tick();

    // reset while the operand-2 beat is pending
    op_valid = 1'b1;
    op_cmd   = CMD_ADD;
    op_data1 = 32'hAA;
    op_data2 = 32'hBB;
    tick();
    op_valid = 1'b0;
    chk("pre_rst_cmd", 64'(req_cmd_out), 64'(CMD_ADD));
    reset = 1'b1;
    #1;
    chk("mid_rst_cmd", 64'(req_cmd_out), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(op_ready), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    issue(CMD_ADD, 32'h9, 32'h1, 2'd0);
    push(2'd0, RESP_OK, 32'hA);
    rsp(RESP_OK, 32'hA, 2'd0);
    tick();
    tick();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
